// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared 640x480@60 VGA timing constants, bus widths and
//                colour constants for the VGA output block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   // Bus widths
   localparam int COLOR_W = 6;
   localparam int COORD_W = 10;

   // 640x480@60 horizontal timing (pixels)
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;

   // 640x480@60 vertical timing (lines)
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   // Colour driven whenever the beam is outside the visible area
   localparam logic [COLOR_W-1:0] BLACK = '0;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
//  Module      : vga_axis_counter
//  Description : One raster axis. Counts 0..TOTAL-1 when enabled, flags the
//                wrap cycle and decodes the active-low sync window
//                SYNC_START <= cnt < SYNC_END combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter #(
   parameter int TOTAL      = 800,
   parameter int SYNC_START = 656,
   parameter int SYNC_END   = 752,
   parameter int W          = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o,
   output logic         sync_n_o
);

   localparam logic [W-1:0] LAST_C  = W'(TOTAL - 1);
   localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
   localparam logic [W-1:0] SYNC_HI = W'(SYNC_END);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Wrap happens on the enabled cycle that sits on the last count
   assign wrap_o = en_i && (cnt_q == LAST_C);

   // Next count: hold, step, or return to zero on wrap
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter register, restarts at zero on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign sync_n_o = !((cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI));

endmodule : vga_axis_counter

`default_nettype wire

// File: rtl/vga_timing_out.sv
// ============================================================================
//  Module      : vga_timing_out
//  Description : 640x480@60 VGA raster timing generator and output stage.
//                Drives pixel coordinates to the pattern generator, takes its
//                colour back, blanks it outside the visible area and
//                registers it onto the VGA pins together with the syncs.
//                Build option VGA_SYNC_ALIGN_EN registers hsync/vsync in the
//                colour stage so sync and colour share a 1-clk latency;
//                otherwise syncs are driven straight from the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_out
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int PIX_DIV  = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic [COORD_W-1:0] colPos,
   output logic [COORD_W-1:0] rowPos,
   output logic               pix_tick,
   output logic               line_start,
   output logic               frame_start,
   output logic               active,
   input  logic [COLOR_W-1:0] color,
   input  logic               display_enable,
   output logic [COLOR_W-1:0] vga_rgb,
   output logic               hsync,
   output logic               vsync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic               h_wrap;
   logic               v_wrap;
   logic               hs_raw;
   logic               vs_raw;
   logic [COLOR_W-1:0] rgb_q;
   logic [COLOR_W-1:0] rgb_d;

   // Pixel-rate divider; with PIX_DIV=1 every clk is a pixel
   generate
      if (PIX_DIV == 1) begin : g_div_bypass
         assign pix_tick = 1'b1;
      end else begin : g_div
         localparam int DIV_W = $clog2(PIX_DIV);
         localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

         logic [DIV_W-1:0] div_cnt_q;
         logic [DIV_W-1:0] div_cnt_d;

         // Next divider count, wrapping on the pixel boundary
         always_comb begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
         end

         // Divider register
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               div_cnt_q <= '0;
            end else begin
               div_cnt_q <= div_cnt_d;
            end
         end

         assign pix_tick = (div_cnt_q == DIV_LAST);
      end
   endgenerate

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
      .W          (COORD_W)
   ) u_h_axis (
      .clk      (clk),
      .reset_n  (reset_n),
      .en_i     (pix_tick),
      .cnt_o    (colPos),
      .wrap_o   (h_wrap),
      .sync_n_o (hs_raw)
   );

   // The vertical axis steps once per completed line
   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
      .W          (COORD_W)
   ) u_v_axis (
      .clk      (clk),
      .reset_n  (reset_n),
      .en_i     (h_wrap),
      .cnt_o    (rowPos),
      .wrap_o   (v_wrap),
      .sync_n_o (vs_raw)
   );

   assign line_start  = h_wrap;
   assign frame_start = v_wrap;
   assign active      = (colPos < COORD_W'(H_ACTIVE)) && (rowPos < COORD_W'(V_ACTIVE));

   // Blank the generator's colour outside the visible area or when disabled
   always_comb begin
      rgb_d = (active && display_enable) ? color : BLACK;
   end

   // Colour output stage, one clk behind the coordinates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q <= BLACK;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign vga_rgb = rgb_q;

`ifdef VGA_SYNC_ALIGN_EN
   logic hsync_q;
   logic vsync_q;

   // Syncs registered alongside colour so both leave on the same edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         hsync_q <= hs_raw;
         vsync_q <= vs_raw;
      end
   end

   assign hsync = hsync_q;
   assign vsync = vsync_q;
`else
   // Syncs taken straight from the counter decode; they lead colour by 1 clk
   assign hsync = hs_raw;
   assign vsync = vs_raw;
`endif

endmodule : vga_timing_out

`default_nettype wire

// File: tb/tb_vga_timing_out.sv
// ============================================================================
//  Module      : tb_vga_timing_out
//  Description : Self-checking bench for vga_timing_out. A full-size instance
//                checks line timing, blanking and colour latency from a
//                vector table; reduced-geometry instances check whole-frame
//                timing, vsync, mid-frame reset and the PIX_DIV=4 divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_out;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] color;
   logic       de;

   always #5 clk = ~clk;

   // Full 640x480 instance
   logic [9:0] f_col, f_row;
   logic       f_tick, f_ls, f_fs, f_act, f_hs, f_vs;
   logic [5:0] f_rgb;

   vga_timing_out u_full (
      .clk(clk), .reset_n(reset_n), .colPos(f_col), .rowPos(f_row),
      .pix_tick(f_tick), .line_start(f_ls), .frame_start(f_fs), .active(f_act),
      .color(color), .display_enable(de), .vga_rgb(f_rgb), .hsync(f_hs), .vsync(f_vs)
   );

   // Small geometry: H 8+2+3+3=16, V 6+1+2+2=11, frame 176 clks
   logic [9:0] s_col, s_row;
   logic       s_tick, s_ls, s_fs, s_act, s_hs, s_vs;
   logic [5:0] s_rgb;

   vga_timing_out #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIX_DIV(1)
   ) u_small (
      .clk(clk), .reset_n(reset_n), .colPos(s_col), .rowPos(s_row),
      .pix_tick(s_tick), .line_start(s_ls), .frame_start(s_fs), .active(s_act),
      .color(color), .display_enable(de), .vga_rgb(s_rgb), .hsync(s_hs), .vsync(s_vs)
   );

   // Same small geometry with PIX_DIV=4, frame 704 clks
   logic [9:0] d_col, d_row;
   logic       d_tick, d_ls, d_fs, d_act, d_hs, d_vs;
   logic [5:0] d_rgb;

   vga_timing_out #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIX_DIV(4)
   ) u_div4 (
      .clk(clk), .reset_n(reset_n), .colPos(d_col), .rowPos(d_row),
      .pix_tick(d_tick), .line_start(d_ls), .frame_start(d_fs), .active(d_act),
      .color(color), .display_enable(de), .vga_rgb(d_rgb), .hsync(d_hs), .vsync(d_vs)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int         col;
      logic [5:0] color;
      logic       de;
      logic [5:0] exp_rgb;
      logic       exp_act;
      logic       exp_hs;
      logic       exp_ls;
   } vec_t;

   vec_t vecs[12];

   initial begin
      bit found;
      int hs_low, ls_cnt, vs_low;
      int e_coord, e_rgb, e_act, e_sync, e_strobe, e_div;
      int m_col, m_row, p_col, p_row, c_col, c_row;
      logic [5:0] exp_rgb;
      int s_first, s_second, d_first, d_second;

      // Row-0 vectors on the full instance, ascending column
      vecs[0]  = '{0,   6'b001100, 1'b1, 6'b001100, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{5,   6'b111111, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{10,  6'b111111, 1'b1, 6'b111111, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{100, 6'b101010, 1'b1, 6'b101010, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{639, 6'b010101, 1'b1, 6'b010101, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{640, 6'b001100, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{655, 6'b111111, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{656, 6'b111111, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{700, 6'b101010, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{751, 6'b111111, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{752, 6'b111111, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{799, 6'b111111, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b1};

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      color   = 6'b000000;
      de      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_col",   f_col, 0);
      chk("rst_row",   f_row, 0);
      chk("rst_rgb",   f_rgb, 0);
      chk("rst_hsync", f_hs, 1);
      chk("rst_vsync", f_vs, 1);
      chk("rst_line_start",  f_ls, 0);
      chk("rst_frame_start", f_fs, 0);
      chk("rst_tick_div1", f_tick, 1);
      chk("rst_tick_div4", d_tick, 0);
      reset_n = 1'b1;

      // ---------------- table-driven row-0 vectors ----------------
      for (int v = 0; v < 12; v++) begin
         found = 1'b0;
         for (int t = 0; t < 1000; t++) begin
            if (f_col == 10'(vecs[v].col) && f_row == 10'd0) begin
               found = 1'b1;
               break;
            end
            @(negedge clk);
         end
         if (!found) begin
            chk($sformatf("vec%0d_reach_col", v), f_col, vecs[v].col);
            break;
         end
         color = vecs[v].color;
         de    = vecs[v].de;
         #1;
         chk($sformatf("vec%0d_active", v), f_act, vecs[v].exp_act);
         chk($sformatf("vec%0d_line_start", v), f_ls, vecs[v].exp_ls);
`ifndef VGA_SYNC_ALIGN_EN
         chk($sformatf("vec%0d_hsync", v), f_hs, vecs[v].exp_hs);
`endif
         @(negedge clk);
         chk($sformatf("vec%0d_rgb", v), f_rgb, vecs[v].exp_rgb);
`ifdef VGA_SYNC_ALIGN_EN
         chk($sformatf("vec%0d_hsync", v), f_hs, vecs[v].exp_hs);
`endif
      end

      // After the col-799 wrap the raster sits at (0,1)
      chk("wrap_col", f_col, 0);
      chk("wrap_row", f_row, 1);

      // One full line: 96 clks of hsync low, exactly one line_start
      hs_low = 0;
      ls_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (!f_hs) hs_low++;
         if (f_ls)  ls_cnt++;
         @(negedge clk);
      end
      chk("line_hsync_low_clks", hs_low, 96);
      chk("line_start_per_line", ls_cnt, 1);

      // ---------------- small frame: coordinates, blanking, syncs ----------------
      color = 6'b001100;
      de    = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (s_fs) begin
            found = 1'b1;
            break;
         end
      end
      chk("sm_first_frame_start_seen", found, 1);
      m_col = 15; m_row = 10;
      e_coord = 0; e_rgb = 0; e_act = 0; e_sync = 0; e_strobe = 0;
      hs_low = 0; vs_low = 0;
      for (int k = 1; k <= 176; k++) begin
         @(negedge clk);
         p_col = m_col;
         p_row = m_row;
         if (m_col == 15) begin
            m_col = 0;
            m_row = (m_row == 10) ? 0 : m_row + 1;
         end else begin
            m_col = m_col + 1;
         end
         if (s_col != 10'(m_col) || s_row != 10'(m_row)) e_coord++;
         exp_rgb = (p_col < 8 && p_row < 6) ? 6'b001100 : 6'b000000;
         if (s_rgb !== exp_rgb) e_rgb++;
         if (s_act !== (m_col < 8 && m_row < 6)) e_act++;
`ifdef VGA_SYNC_ALIGN_EN
         c_col = p_col; c_row = p_row;
`else
         c_col = m_col; c_row = m_row;
`endif
         if (s_hs !== !(c_col >= 10 && c_col < 13)) e_sync++;
         if (s_vs !== !(c_row >= 7 && c_row < 9))   e_sync++;
         if (s_ls !== (m_col == 15)) e_strobe++;
         if (s_fs !== (m_col == 15 && m_row == 10)) e_strobe++;
         if (!s_hs) hs_low++;
         if (!s_vs) vs_low++;
      end
      chk("sm_coord_errors",  e_coord, 0);
      chk("sm_rgb_errors",    e_rgb, 0);
      chk("sm_active_errors", e_act, 0);
      chk("sm_sync_errors",   e_sync, 0);
      chk("sm_strobe_errors", e_strobe, 0);
      chk("sm_frame_start_at_176", s_fs, 1);
      chk("sm_hsync_low_clks", hs_low, 33);
      chk("sm_vsync_low_clks", vs_low, 32);

      // ---------------- mid-frame reset ----------------
      found = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (s_col == 10'd5 && s_row == 10'd3) begin
            found = 1'b1;
            break;
         end
      end
      chk("mid_reach_5_3", found, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_col",   s_col, 0);
      chk("mid_rst_row",   s_row, 0);
      chk("mid_rst_rgb",   s_rgb, 0);
      chk("mid_rst_hsync", s_hs, 1);
      chk("mid_rst_vsync", s_vs, 1);
      chk("mid_rst_frame_start", s_fs, 0);
      chk("mid_rst_full_col", f_col, 0);
      chk("mid_rst_div4_col", d_col, 0);
      chk("mid_rst_div4_tick", d_tick, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      s_first = -1; s_second = -1; d_first = -1; d_second = -1;
      e_div = 0;
      for (int i = 1; i <= 1500; i++) begin
         @(negedge clk);
         if (i <= 12) begin
            if (d_col != 10'(i / 4))          e_div++;
            if (d_tick !== ((i % 4) == 3))    e_div++;
         end
         if (i == 1) begin
            chk("post_rst_hsync", s_hs, 1);
            chk("post_rst_vsync", s_vs, 1);
         end
         if (s_fs) begin
            if (s_first < 0) s_first = i;
            else if (s_second < 0) s_second = i;
         end
         if (d_fs) begin
            if (d_first < 0) d_first = i;
            else if (d_second < 0) d_second = i;
         end
      end
      chk("div4_step_errors", e_div, 0);
      chk("sm_first_frame_after_reset", s_first, 175);
      chk("sm_frame_period", s_second - s_first, 176);
      chk("div4_first_frame_after_reset", d_first, 703);
      chk("div4_frame_period", d_second - d_first, 704);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_vga_timing_out

`default_nettype wire
